// File: rtl/pc_fetch_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared definitions for the PC fetch controller slice.
//   fetch_state_e         : controller state encoding (IDLE/FETCH/HOLD/TRAP)
//   INSTR_BYTES           : instruction width in bytes (word fetch)
//   DEFAULT_RESET_VECTOR  : default address loaded into pc on reset
//   is_word_aligned()     : true when an address is instruction aligned
// ----------------------------------------------------------------------------
package pc_fetch_pkg;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr & 32'(INSTR_BYTES - 1)) == 32'd0;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_target_mux.sv
// ----------------------------------------------------------------------------
// pc_target_mux
// Selects the candidate next pc: the redirect target when branchTaken is set,
// otherwise the sequential pcNext. Also reports whether the redirect target is
// misaligned.
//
// Build option (macro PC_MISALIGN_TRAP_EN):
//   defined   : target passed through unmodified, misalignment reported so the
//               controller can trap.
//   undefined : target low bits forced to zero, misalignment never reported.
//
// Ports:
//   branchTaken      in   redirect select
//   branchTarget     in   redirect address
//   pcNext           in   sequential address (pc + 4)
//   nextPc           out  selected candidate address
//   targetMisaligned out  redirect target is not word aligned
// ----------------------------------------------------------------------------
module pc_target_mux
    import pc_fetch_pkg::*;
(
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic [31:0] pcNext,
    output logic [31:0] nextPc,
    output logic        targetMisaligned
);

`ifdef PC_MISALIGN_TRAP_EN
    // A misaligned target is never loaded; the controller traps instead.
    assign nextPc           = branchTaken ? branchTarget : pcNext;
    assign targetMisaligned = branchTaken && !is_word_aligned(branchTarget);
`else
    // Masking the byte-offset bits makes every redirect land on a word.
    logic [31:0] aligned_target;
    assign aligned_target   = branchTarget & ~32'(INSTR_BYTES - 1);
    assign nextPc           = branchTaken ? aligned_target : pcNext;
    assign targetMisaligned = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
// Program counter and instruction fetch controller. Issues one word fetch per
// cycle at pc, advances on each completed handshake, holds while the pipeline
// stalls and redirects on taken branches (squashing any wrong-path fetch).
//
// Build option: PC_MISALIGN_TRAP_EN -- when defined, a misaligned redirect
// target parks the controller in TRAP with a sticky misaligned flag until
// reset; when undefined, targets are silently word aligned.
//
// Ports:
//   clock         in   clock, rising edge
//   reset         in   synchronous active-high reset
//   pcNext        in   pc + 4 from the external PC adder
//   branchTaken   in   redirect request
//   branchTarget  in   redirect address
//   stall         in   pipeline cannot accept an instruction
//   imemReady     in   instruction memory completes the request this cycle
//   pc            out  current fetch address
//   imemReq       out  fetch request
//   imemAddr      out  fetch address (equals pc)
//   fetchValid    out  instruction at pc delivered this cycle
//   misaligned    out  sticky misaligned-redirect fault
// ----------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pcNext,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        stall,
    input  logic        imemReady,
    output logic [31:0] pc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic        fetchValid,
    output logic        misaligned
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] FETCH = ST_FETCH;
    localparam logic [1:0] HOLD  = ST_HOLD;
    localparam logic [1:0] TRAP  = ST_TRAP;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        misaligned_reg, misaligned_next;

    logic [31:0] cand_pc;
    logic        cand_misaligned;
    logic        handshake;

    pc_target_mux u_target_mux (
        .branchTaken      (branchTaken),
        .branchTarget     (branchTarget),
        .pcNext           (pcNext),
        .nextPc           (cand_pc),
        .targetMisaligned (cand_misaligned)
    );

    // Reset also masks the request combinationally so an in-flight fetch is
    // dropped in the very cycle reset is asserted.
    assign imemReq    = (state_reg == FETCH) && !stall && !reset;
    assign handshake  = imemReq && imemReady;
    // A redirect squashes the delivery even if memory completes the request.
    assign fetchValid = handshake && !branchTaken;

    assign pc         = pc_reg;
    assign imemAddr   = pc_reg;
    assign misaligned = misaligned_reg;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        misaligned_next = misaligned_reg;
        case (state_reg)
            IDLE: state_next = FETCH;
            FETCH, HOLD: begin
                if (branchTaken) begin
                    if (cand_misaligned) begin
                        state_next      = TRAP;
                        misaligned_next = 1'b1;
                    end else begin
                        // Redirect wins over stall; a still-present stall is
                        // seen again next cycle from FETCH.
                        state_next = FETCH;
                        pc_next    = cand_pc;
                    end
                end else if (state_reg == HOLD) begin
                    if (!stall) begin
                        state_next = FETCH;
                    end
                end else if (stall) begin
                    state_next = HOLD;
                end else if (imemReady) begin
                    pc_next = cand_pc;
                end
            end
            TRAP: state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_VECTOR;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            misaligned_reg <= misaligned_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pcNext;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        stall;
    logic        imemReady;
    logic [31:0] pc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        fetchValid;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // External PC adder.
    assign pcNext = pc + 32'd4;

    pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
        .clock        (clock),
        .reset        (reset),
        .pcNext       (pcNext),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .stall        (stall),
        .imemReady    (imemReady),
        .pc           (pc),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .fetchValid   (fetchValid),
        .misaligned   (misaligned)
    );

    typedef struct {
        bit          rst;
        bit          br;
        bit          stl;
        bit          rdy;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        bit          e_req;
        bit          e_fv;
        bit          e_mis;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t mk(bit rst, bit br, bit stl, bit rdy, logic [31:0] tgt,
                                logic [31:0] e_pc, bit e_req, bit e_fv, bit e_mis);
        vec_t v;
        v.rst = rst; v.br = br; v.stl = stl; v.rdy = rdy; v.tgt = tgt;
        v.e_pc = e_pc; v.e_req = e_req; v.e_fv = e_fv; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit br, input logic [31:0] tgt,
                         input bit stl, input bit rdy);
        @(negedge clock);
        reset        = rst;
        branchTaken  = br;
        branchTarget = tgt;
        stall        = stl;
        imemReady    = rdy;
        #1;
    endtask

    // Reference model: pipeline phase flags plus the architectural pc.
    bit          m_in_idle;
    bit          m_parked;
    bit          m_dead;
    bit          m_fault;
    logic [31:0] m_pc;

    task automatic model_reset();
        m_in_idle = 1'b1; m_parked = 1'b0; m_dead = 1'b0; m_fault = 1'b0; m_pc = RV;
    endtask

    task automatic model_edge(input bit rst, input bit br, input logic [31:0] tgt,
                              input bit stl, input bit rdy);
        if (rst) begin
            model_reset();
        end else if (m_in_idle) begin
            m_in_idle = 1'b0;
        end else if (!m_dead) begin
            if (br) begin
                if (TE && tgt[1:0] != 2'b00) begin
                    m_dead  = 1'b1;
                    m_fault = 1'b1;
                end else begin
                    m_pc     = tgt - (tgt % 4);
                    m_parked = 1'b0;
                end
            end else if (m_parked) begin
                m_parked = stl;
            end else if (stl) begin
                m_parked = 1'b1;
            end else if (rdy) begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    initial begin
        bit          rst, br, stl, rdy, e_req, e_fv;
        logic [31:0] tgt;

        reset = 1'b1; branchTaken = 1'b0; branchTarget = '0; stall = 1'b0; imemReady = 1'b0;

        //                rst br stl rdy tgt            e_pc                        req          fv           mis
        vecs[0]  = mk(1, 0, 0, 1, 32'h0,        32'h100,                    0,           0,           0);
        vecs[1]  = mk(0, 0, 0, 1, 32'h0,        32'h100,                    0,           0,           0);
        vecs[2]  = mk(0, 0, 0, 1, 32'h0,        32'h100,                    1,           1,           0);
        vecs[3]  = mk(0, 0, 0, 1, 32'h0,        32'h104,                    1,           1,           0);
        vecs[4]  = mk(0, 0, 0, 1, 32'h0,        32'h108,                    1,           1,           0);
        vecs[5]  = mk(0, 1, 0, 0, 32'h200,      32'h10C,                    1,           0,           0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,        32'h200,                    1,           0,           0);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,        32'h200,                    1,           0,           0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,        32'h200,                    1,           0,           0);
        vecs[9]  = mk(0, 0, 0, 0, 32'h0,        32'h200,                    1,           0,           0);
        vecs[10] = mk(0, 0, 0, 1, 32'h0,        32'h200,                    1,           1,           0);
        vecs[11] = mk(0, 1, 0, 1, 32'h300,      32'h204,                    1,           0,           0);
        vecs[12] = mk(0, 0, 1, 1, 32'h0,        32'h300,                    0,           0,           0);
        vecs[13] = mk(0, 0, 1, 1, 32'h0,        32'h300,                    0,           0,           0);
        vecs[14] = mk(0, 0, 0, 1, 32'h0,        32'h300,                    0,           0,           0);
        vecs[15] = mk(0, 0, 0, 1, 32'h0,        32'h300,                    1,           1,           0);
        vecs[16] = mk(0, 1, 0, 0, 32'h20C,      32'h304,                    1,           0,           0);
        vecs[17] = mk(0, 1, 0, 1, 32'h400,      32'h20C,                    1,           0,           0);
        vecs[18] = mk(0, 0, 0, 0, 32'h0,        32'h400,                    1,           0,           0);
        vecs[19] = mk(0, 1, 0, 1, 32'h402,      32'h400,                    1,           0,           0);
        vecs[20] = mk(0, 0, 0, 1, 32'h0,        32'h400,                    !TE,         !TE,         TE);
        vecs[21] = mk(0, 0, 0, 1, 32'h0,        TE ? 32'h400 : 32'h404,     !TE,         !TE,         TE);
        vecs[22] = mk(1, 0, 0, 1, 32'h0,        TE ? 32'h400 : 32'h408,     0,           0,           TE);
        vecs[23] = mk(0, 0, 0, 0, 32'h0,        32'h100,                    0,           0,           0);
        vecs[24] = mk(0, 1, 0, 0, 32'h500,      32'h100,                    1,           0,           0);
        vecs[25] = mk(1, 0, 0, 1, 32'h0,        32'h500,                    0,           0,           0);
        vecs[26] = mk(0, 0, 0, 1, 32'h0,        32'h100,                    0,           0,           0);
        vecs[27] = mk(0, 0, 0, 1, 32'h0,        32'h100,                    1,           1,           0);
        vecs[28] = mk(0, 1, 0, 0, 32'hFFFF_FFFC, 32'h104,                   1,           0,           0);
        vecs[29] = mk(0, 0, 0, 1, 32'h0,        32'hFFFF_FFFC,              1,           1,           0);
        vecs[30] = mk(0, 0, 0, 1, 32'h0,        32'h0,                      1,           1,           0);
        vecs[31] = mk(0, 0, 1, 1, 32'h0,        32'h4,                      0,           0,           0);
        vecs[32] = mk(0, 1, 1, 1, 32'h600,      32'h4,                      0,           0,           0);
        vecs[33] = mk(0, 0, 0, 1, 32'h0,        32'h600,                    1,           1,           0);

        // Bring pc to a known value before the table starts comparing.
        drive(1, 0, 32'h0, 0, 0);
        drive(1, 0, 32'h0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].br, vecs[i].tgt, vecs[i].stl, vecs[i].rdy);
            $display("vec %0d rst=%0b br=%0b tgt=%h stall=%0b rdy=%0b pc=%h req=%0b fv=%0b mis=%0b",
                     i, vecs[i].rst, vecs[i].br, vecs[i].tgt, vecs[i].stl, vecs[i].rdy,
                     pc, imemReq, fetchValid, misaligned);
            chk($sformatf("vec%0d_pc", i),   pc,         vecs[i].e_pc);
            chk($sformatf("vec%0d_addr", i), imemAddr,   vecs[i].e_pc);
            chk($sformatf("vec%0d_req", i),  32'(imemReq),    32'(vecs[i].e_req));
            chk($sformatf("vec%0d_fv", i),   32'(fetchValid), 32'(vecs[i].e_fv));
            chk($sformatf("vec%0d_mis", i),  32'(misaligned), 32'(vecs[i].e_mis));
        end

        // Randomized phase against the reference model.
        drive(1, 0, 32'h0, 0, 0);
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(99) < 2);
            br  = ($urandom_range(99) < 15);
            stl = ($urandom_range(99) < 25);
            rdy = ($urandom_range(99) < 60);
            tgt = $urandom;
            if ($urandom_range(99) < 80) tgt[1:0] = 2'b00;
            drive(rst, br, tgt, stl, rdy);
            e_req = !rst && !m_in_idle && !m_dead && !m_parked && !stl;
            e_fv  = e_req && rdy && !br;
            $display("rnd %0d rst=%0b br=%0b tgt=%h stall=%0b rdy=%0b pc=%h req=%0b fv=%0b mis=%0b",
                     n, rst, br, tgt, stl, rdy, pc, imemReq, fetchValid, misaligned);
            chk("rnd_pc",   pc,               m_pc);
            chk("rnd_addr", imemAddr,         m_pc);
            chk("rnd_req",  32'(imemReq),     32'(e_req));
            chk("rnd_fv",   32'(fetchValid),  32'(e_fv));
            chk("rnd_mis",  32'(misaligned),  32'(m_fault));
            model_edge(rst, br, tgt, stl, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, address loaded into pc on reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pcNext  input  32  sequential next address from the PC adder, equal to pc+4.
REQ-005 branchTaken  input  1  redirect request, valid in the same cycle as branchTarget.
REQ-006 branchTarget  input  32  redirect address.
REQ-007 stall  input  1  pipeline cannot accept a new instruction this cycle.
REQ-008 imemReady  input  1  instruction memory accepts and completes the request this cycle.
REQ-009 pc  output  32  current fetch address; drives the PC adder.
REQ-010 imemReq  output  1  fetch request to instruction memory.
REQ-011 imemAddr  output  32  fetch address, always equal to pc.
REQ-012 fetchValid  output  1  one-cycle pulse: instruction at pc delivered to the pipeline.
REQ-013 misaligned  output  1  sticky fault flag: redirect target not word-aligned.

Function
REQ-014 States SHALL be IDLE, FETCH, HOLD and TRAP.
REQ-015 IDLE SHALL last exactly one cycle after reset deassertion, then go to FETCH.
REQ-016 In FETCH, imemReq SHALL equal !stall.
- Handshake = imemReq && imemReady.
REQ-017 On a handshake with branchTaken=0: fetchValid=1 and pc <= pcNext in the same edge.
- One fetch per cycle at full throughput.
REQ-018 Redirect: branchTaken=1 in FETCH or HOLD SHALL set pc <= branchTarget.
- fetchValid SHALL be 0 that cycle (wrong-path squash), even if a handshake occurs.
REQ-019 A request abandoned by a redirect SHALL NOT be retried at the old address; the next request SHALL use the new pc.
REQ-020 FETCH with stall=1 and branchTaken=0 SHALL go to HOLD with pc unchanged.
REQ-021 HOLD SHALL return to FETCH on the first cycle with stall=0.
- imemReq=0 while in HOLD.
REQ-022 Input priority SHALL be reset > branchTaken > stall > handshake.
REQ-023 pc arithmetic is the caller's: pcNext wrap from 32'hFFFF_FFFC to 32'h0 SHALL be accepted without fault.
REQ-024 imemReq and fetchValid SHALL be 0 in IDLE and TRAP.

Reset
REQ-025 reset=1 SHALL force: state IDLE, pc=RESET_VECTOR, imemReq=0, fetchValid=0, misaligned=0.
- Applies from any state, including mid-handshake and TRAP; the in-flight fetch is discarded.

Configuration
REQ-026 Macro PC_MISALIGN_TRAP_EN defined: a redirect with branchTarget[1:0]!=0 SHALL go to TRAP.
- pc SHALL keep its prior value.
- misaligned SHALL be set and held until reset.
REQ-027 PC_MISALIGN_TRAP_EN undefined: branchTarget[1:0] SHALL be forced to 2'b00.
- misaligned SHALL be tied to 0.
- TRAP SHALL be unreachable.

Structure
REQ-028 Package pc_fetch_pkg SHALL hold the state enum typedef, INSTR_BYTES=4 and the default RESET_VECTOR.
REQ-029 The redirect/sequential next-pc select (including alignment masking) SHALL be a sub-module, pc_target_mux.
REQ-030 Target implementation size: 120-400 lines RTL total.

Verification
REQ-031 Reset with RESET_VECTOR=32'h100, then imemReady=1 for 3 cycles.
- IDLE for 1 cycle.
- Addresses 0x100, 0x104, 0x108, each with fetchValid=1.
REQ-032 imemReady=0 for 4 cycles at pc=0x200, then 1.
- imemReq held high with imemAddr=0x200 throughout.
- A single fetchValid pulse, then pc=0x204.
REQ-033 stall=1 for 2 cycles at pc=0x300.
- HOLD with imemReq=0 and pc held at 0x300.
- Resumes at 0x300 on the first cycle with stall=0.
REQ-034 branchTaken=1 with branchTarget=0x400, coinciding with a handshake at 0x20C.
- fetchValid=0 that cycle.
- Next request at 0x400.
REQ-035 PC_MISALIGN_TRAP_EN defined, branchTarget=0x402.
- misaligned=1, imemReq=0, pc unchanged until reset.
- Undefined: pc=0x400, no fault.
REQ-036 reset asserted while imemReq=1 at 0x500.
- Next cycle: pc=RESET_VECTOR, imemReq=0, no fetchValid.
